// File: rtl/config_button_control_pkg.sv
// Shared constants for the configuration button controller.
// Holds the FSM state encoding and the field codes so that the
// downstream field counters compare against exactly the same values.
package config_button_control_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_CONFIG = 1'b1
    } state_t;

    // Field codes driven on en_count. 0 means no field selected.
    typedef logic [3:0] field_t;

    localparam field_t FIELD_NONE   = 4'd0;
    localparam field_t FIELD_HOUR   = 4'd1;
    localparam field_t FIELD_MINUTE = 4'd2;
    localparam field_t FIELD_SECOND = 4'd3;
    localparam field_t FIELD_YEAR   = 4'd4;
    localparam field_t FIELD_MONTH  = 4'd5;
    localparam field_t FIELD_DAY    = 4'd6;

    // Bit positions of the buttons inside the internal button vectors.
    localparam int BTN_CONFIG = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 4;
    localparam int NUM_BTNS   = 5;

endpackage

// File: rtl/config_button_control_debounce_btn.sv
// debounce_btn: conditions one raw pushbutton.
//   - 2-flop synchronizer on the raw input
//   - stability counter: the debounced level follows the synchronized
//     input only after it has differed for DEB_CYCLES consecutive cycles;
//     any reversion clears the counter
//   - registered one-cycle rising-edge pulse, high the cycle after the
//     debounced level goes 0->1
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   btn_raw    : raw (asynchronous) button input
//   level      : debounced button level
//   rise       : one-cycle pulse on a debounced 0->1 transition
module debounce_btn #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             prev_q, prev_d;
    logic             rise_q, rise_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            // This cycle is the DEB_CYCLES-th consecutive differing one.
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        prev_d = level_q;
        rise_d = level_q & ~prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/config_button_control.sv
// config_button_control: front-panel controller for clock/date editing.
// Five debounced buttons drive a two-state FSM (IDLE / CONFIG). In CONFIG
// the right/left buttons walk the selected field (1..NUM_FIELDS, wrapping)
// and the up/down buttons are passed on as held levels to the field
// counters, which sample them on a slow strobe.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   btn_config      : raw button, toggles configuration mode
//   btn_right/left  : raw buttons, next/previous field
//   btn_up/down     : raw buttons, increment/decrement selected field
//   en_count        : selected field code (0 in IDLE), registered
//   enUP / enDOWN   : increment / decrement request levels, registered
//   config_mode     : high while in CONFIG
//   dbg_state       : current FSM state
module config_button_control
    import config_button_control_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000,
    parameter int NUM_FIELDS = 6   // legal range 1..15 (4-bit field code)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_config,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       config_mode,
    output state_t     dbg_state
);

    localparam field_t LAST_FIELD = field_t'(NUM_FIELDS);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_rise;

    assign btn_raw = {btn_down, btn_up, btn_left, btn_right, btn_config};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_deb
        debounce_btn #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_debounce_btn (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn_raw[i]),
            .level  (btn_level[i]),
            .rise   (btn_rise[i])
        );
    end

    // Navigation buttons act on edges only; up/down act on levels only.
    logic unused;
    assign unused = ^{btn_level[BTN_LEFT:BTN_CONFIG], btn_rise[BTN_DOWN:BTN_UP]};

    state_t state_q, state_d;
    field_t field_q, field_d;
    field_t en_count_q, en_count_d;
    logic   en_up_q, en_up_d;
    logic   en_down_q, en_down_d;

    logic cfg_edge, right_edge, left_edge, up_lvl, down_lvl;
    assign cfg_edge   = btn_rise[BTN_CONFIG];
    assign right_edge = btn_rise[BTN_RIGHT];
    assign left_edge  = btn_rise[BTN_LEFT];
    assign up_lvl     = btn_level[BTN_UP];
    assign down_lvl   = btn_level[BTN_DOWN];

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_edge) begin
                    state_d = ST_CONFIG;
                    field_d = FIELD_HOUR;
                end
            end
            ST_CONFIG: begin
                // A config edge wins over any simultaneous navigation edge;
                // right+left together cancel out.
                if (cfg_edge) begin
                    state_d = ST_IDLE;
                end else if (right_edge && !left_edge) begin
                    field_d = (field_q >= LAST_FIELD) ? FIELD_HOUR : field_q + 4'd1;
                end else if (left_edge && !right_edge) begin
                    field_d = (field_q <= FIELD_HOUR) ? LAST_FIELD : field_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // config_mode, one cycle after the causing edge pulse.
        en_count_d = (state_d == ST_CONFIG) ? field_d : FIELD_NONE;
        en_up_d    = (state_d == ST_CONFIG) && up_lvl && !down_lvl;
        en_down_d  = (state_d == ST_CONFIG) && down_lvl && !up_lvl;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            field_q    <= FIELD_HOUR;
            en_count_q <= FIELD_NONE;
            en_up_q    <= 1'b0;
            en_down_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            field_q    <= field_d;
            en_count_q <= en_count_d;
            en_up_q    <= en_up_d;
            en_down_q  <= en_down_d;
        end
    end

    assign en_count    = en_count_q;
    assign enUP        = en_up_q;
    assign enDOWN      = en_down_q;
    assign config_mode = (state_q == ST_CONFIG);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_config_button_control.sv
// Directed bench for config_button_control with DEB_CYCLES = 4.
// Latency from a press applied just after an edge: synchronizer 2 edges,
// debounce 4 edges (level at edge 6), edge pulse at edge 7, registered
// outputs at edge 8. enUP/enDOWN follow the level, so they rise at edge 7.
module tb_config_button_control;
    import config_button_control_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] btn;  // {down, up, left, right, config}
    logic [3:0] en_count;
    logic       en_up;
    logic       en_down;
    logic       config_mode;
    state_t     dbg_state;

    int n_checks;
    int n_fail;

    config_button_control #(
        .DEB_CYCLES(4),
        .NUM_FIELDS(6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_config (btn[0]),
        .btn_right  (btn[1]),
        .btn_left   (btn[2]),
        .btn_up     (btn[3]),
        .btn_down   (btn[4]),
        .en_count   (en_count),
        .enUP       (en_up),
        .enDOWN     (en_down),
        .config_mode(config_mode),
        .dbg_state  (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a button for 'hold' cycles, release, let the release settle.
    task automatic press(input int idx, input int hold);
        btn[idx] = 1'b1;
        step(hold);
        btn[idx] = 1'b0;
        step(10);
    endtask

    task automatic test_reset;
        btn   = '0;
        reset = 1'b1;
        step(3);
        n_checks++; if (en_count !== 4'd0) begin n_fail++; $display("FAIL reset_en_count: got %0d want 0", en_count); end
        n_checks++; if (en_up !== 1'b0 || en_down !== 1'b0) begin n_fail++; $display("FAIL reset_en_updown: got %b%b want 00", en_up, en_down); end
        n_checks++; if (config_mode !== 1'b0) begin n_fail++; $display("FAIL reset_config_mode: got %b want 0", config_mode); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_glitch;
        for (int g = 2; g <= 3; g++) begin
            btn[0] = 1'b1;
            step(g);
            btn[0] = 1'b0;
            step(12);
            n_checks++; if (config_mode !== 1'b0 || en_count !== 4'd0) begin n_fail++; $display("FAIL glitch_%0d: config_mode=%b en_count=%0d want 0/0", g, config_mode, en_count); end
        end
    endtask

    task automatic test_enter_config;
        logic exp;
        btn[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step(1);
            exp = (c >= 8);
            n_checks++; if (config_mode !== exp) begin n_fail++; $display("FAIL enter_config_mode c=%0d: got %b want %b", c, config_mode, exp); end
            n_checks++; if (en_count !== {3'b000, exp}) begin n_fail++; $display("FAIL enter_en_count c=%0d: got %0d want %0d", c, en_count, exp); end
        end
        btn[0] = 1'b0;
        step(10);
        n_checks++; if (config_mode !== 1'b1 || en_count !== 4'd1) begin n_fail++; $display("FAIL enter_release: config_mode=%b en_count=%0d want 1/1", config_mode, en_count); end
    endtask

    task automatic test_field_wrap;
        for (int i = 2; i <= 6; i++) begin
            press(1, 8);
            n_checks++; if (en_count !== 4'(i)) begin n_fail++; $display("FAIL right_step: got %0d want %0d", en_count, i); end
        end
        press(1, 8);
        n_checks++; if (en_count !== 4'd1) begin n_fail++; $display("FAIL right_wrap: got %0d want 1", en_count); end
        press(2, 8);
        n_checks++; if (en_count !== 4'd6) begin n_fail++; $display("FAIL left_wrap: got %0d want 6", en_count); end
        press(2, 8);
        n_checks++; if (en_count !== 4'd5) begin n_fail++; $display("FAIL left_step5: got %0d want 5", en_count); end
        press(2, 8);
        n_checks++; if (en_count !== 4'd4) begin n_fail++; $display("FAIL left_step4: got %0d want 4", en_count); end
    endtask

    task automatic test_up_down;
        logic exp;
        btn[3] = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            step(1);
            exp = (c >= 7);
            n_checks++; if (en_up !== exp || en_down !== 1'b0) begin n_fail++; $display("FAIL up_hold c=%0d: enUP=%b enDOWN=%b want %b/0", c, en_up, en_down, exp); end
        end
        btn[4] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step(1);
            exp = (c < 7);
            n_checks++; if (en_up !== exp || en_down !== 1'b0) begin n_fail++; $display("FAIL both_held c=%0d: enUP=%b enDOWN=%b want %b/0", c, en_up, en_down, exp); end
        end
        btn[3] = 1'b0;
        btn[4] = 1'b0;
        step(10);
        n_checks++; if (en_up !== 1'b0 || en_down !== 1'b0) begin n_fail++; $display("FAIL both_release: enUP=%b enDOWN=%b want 0/0", en_up, en_down); end
        btn[4] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step(1);
            exp = (c >= 7);
            n_checks++; if (en_down !== exp || en_up !== 1'b0) begin n_fail++; $display("FAIL down_hold c=%0d: enUP=%b enDOWN=%b want 0/%b", c, en_up, en_down, exp); end
        end
        btn[4] = 1'b0;
        step(10);
        n_checks++; if (en_down !== 1'b0 || en_count !== 4'd4) begin n_fail++; $display("FAIL down_release: enDOWN=%b en_count=%0d want 0/4", en_down, en_count); end
    endtask

    task automatic test_simultaneous;
        btn[1] = 1'b1;
        btn[2] = 1'b1;
        step(8);
        btn[1] = 1'b0;
        btn[2] = 1'b0;
        step(10);
        n_checks++; if (en_count !== 4'd4) begin n_fail++; $display("FAIL right_left_same: got %0d want 4", en_count); end
        btn[0] = 1'b1;
        btn[1] = 1'b1;
        step(8);
        btn[0] = 1'b0;
        btn[1] = 1'b0;
        step(10);
        n_checks++; if (en_count !== 4'd0 || config_mode !== 1'b0) begin n_fail++; $display("FAIL config_right_same: en_count=%0d config_mode=%b want 0/0", en_count, config_mode); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL config_right_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_idle_buttons;
        int idx_list[4] = '{3, 4, 2, 1};
        foreach (idx_list[k]) begin
            btn[idx_list[k]] = 1'b1;
            for (int c = 1; c <= 10; c++) begin
                step(1);
                n_checks++; if (en_count !== 4'd0 || en_up !== 1'b0 || en_down !== 1'b0) begin n_fail++; $display("FAIL idle_btn%0d c=%0d: en_count=%0d enUP=%b enDOWN=%b want 0/0/0", idx_list[k], c, en_count, en_up, en_down); end
            end
            btn[idx_list[k]] = 1'b0;
            step(10);
        end
    endtask

    task automatic test_reset_mid_press;
        press(0, 8);
        n_checks++; if (en_count !== 4'd1 || config_mode !== 1'b1) begin n_fail++; $display("FAIL rmp_enter: en_count=%0d config_mode=%b want 1/1", en_count, config_mode); end
        btn[3] = 1'b1;
        step(10);
        n_checks++; if (en_up !== 1'b1) begin n_fail++; $display("FAIL rmp_up_before: got %b want 1", en_up); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (en_up !== 1'b0 || en_down !== 1'b0 || en_count !== 4'd0 || config_mode !== 1'b0) begin n_fail++; $display("FAIL rmp_async: enUP=%b enDOWN=%b en_count=%0d config_mode=%b want 0", en_up, en_down, en_count, config_mode); end
        step(1);
        reset = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            step(1);
            n_checks++; if (en_up !== 1'b0 || config_mode !== 1'b0) begin n_fail++; $display("FAIL rmp_idle c=%0d: enUP=%b config_mode=%b want 0/0", c, en_up, config_mode); end
        end
        press(0, 8);
        n_checks++; if (en_count !== 4'd1 || en_up !== 1'b1) begin n_fail++; $display("FAIL rmp_reenter: en_count=%0d enUP=%b want 1/1", en_count, en_up); end
        btn[3] = 1'b0;
        step(10);
        n_checks++; if (en_up !== 1'b0) begin n_fail++; $display("FAIL rmp_up_release: got %b want 0", en_up); end
        press(0, 8);
        n_checks++; if (config_mode !== 1'b0 || en_count !== 4'd0) begin n_fail++; $display("FAIL rmp_exit: config_mode=%b en_count=%0d want 0/0", config_mode, en_count); end
    endtask

    task automatic test_reset_redebounce;
        logic exp;
        btn[0] = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step(1);
            exp = (c >= 8);
            n_checks++; if (config_mode !== exp) begin n_fail++; $display("FAIL redebounce c=%0d: config_mode=%b want %b", c, config_mode, exp); end
        end
        btn[0] = 1'b0;
        step(10);
        n_checks++; if (en_count !== 4'd1) begin n_fail++; $display("FAIL redebounce_field: got %0d want 1", en_count); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        btn      = '0;
        reset    = 1'b1;
        test_reset();
        test_glitch();
        test_enter_config();
        test_field_wrap();
        test_up_down();
        test_simultaneous();
        test_idle_buttons();
        test_reset_mid_press();
        test_reset_redebounce();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
